// File: rtl/test_monitor.sv
// End-of-test monitor: snoops GPR writes (or halt/a0) and latches PASS/FAIL/TIMEOUT status.
// Optional watchdog enabled by defining TEST_MONITOR_WDT_EN.
module test_monitor #(
    parameter int XLEN           = 64,
    parameter int MODE           = 0,
    parameter int TESTNUM_REG    = 3,
    parameter int END_REG        = 26,
    parameter int RESULT_REG     = 27,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             wen_i,
    input  logic [4:0]       waddr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic             halt_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [XLEN-1:0]  fail_testnum_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

`ifdef TEST_MONITOR_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif
    // A limit the counter can never represent must never fire (no truncated compare).
    localparam bit               WDT_REACH = ((TIMEOUT_CYCLES - 1) >> CNT_W) == 0;
    localparam logic [CNT_W-1:0] WDT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  testnum_q, result_q, a0_q;
    logic [XLEN-1:0]  testnum_fwd, a0_fwd;
    logic [XLEN-1:0]  ftn_q;
    logic [CNT_W-1:0] cnt_q;
    logic             terminal, wr_ok, hit_tn, hit_res, hit_a0;
    logic             end_hit, end_pass, wdt_exp;

    assign terminal = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
    assign wr_ok    = wen_i && (waddr_i != 5'd0) && !terminal;
    assign hit_tn   = wr_ok && (waddr_i == 5'(TESTNUM_REG));
    assign hit_res  = wr_ok && (waddr_i == 5'(RESULT_REG));
    assign hit_a0   = wr_ok && (waddr_i == 5'd10);

    assign testnum_fwd = hit_tn ? wdata_i : testnum_q;
    assign a0_fwd      = hit_a0 ? wdata_i : a0_q;

    // MODE 0 ends on "x[END_REG] <= 1"; MODE 1 ends on halt and judges a0.
    assign end_hit = (state_q == S_RUN) &&
                     ((MODE == 0) ? (wen_i && (waddr_i != 5'd0) &&
                                     (waddr_i == 5'(END_REG)) && (wdata_i == XLEN'(1)))
                                  : halt_i);
    assign end_pass = (MODE == 0) ? (result_q == XLEN'(1)) : (a0_fwd == '0);
    assign wdt_exp  = WDT_EN && WDT_REACH && (state_q == S_RUN) && (cnt_q == WDT_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_RUN;
            S_RUN: begin
                if (end_hit)      state_d = end_pass ? S_PASS : S_FAIL;
                else if (wdt_exp) state_d = S_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            testnum_q <= '0;
            result_q  <= '0;
            a0_q      <= '0;
            ftn_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (hit_tn)  testnum_q <= wdata_i;
            if (hit_res) result_q  <= wdata_i;
            if (hit_a0)  a0_q      <= wdata_i;
            if ((state_q == S_RUN) && (state_d != S_RUN))
                ftn_q <= testnum_fwd;
            // The count freezes on the terminal edge, so it reads the last live RUN cycle index.
            if ((state_q == S_RUN) && (state_d == S_RUN) && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o         = terminal;
    assign pass_o         = (state_q == S_PASS);
    assign fail_o         = (state_q == S_FAIL);
    assign timeout_o      = WDT_EN && (state_q == S_TIMEOUT);
    assign fail_testnum_o = ftn_q;
    assign cycle_count_o  = cnt_q;

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter XLEN, default 64: width of register write data and shadow registers.
REQ-002 Parameter MODE, default 0: end-of-test protocol; 0 = register protocol, 1 = halt/a0 protocol.
REQ-003 Parameter TESTNUM_REG, default 3: GPR index holding the current test number.
REQ-004 Parameter END_REG, default 26: GPR index whose write of 1 signals test end (MODE 0).
REQ-005 Parameter RESULT_REG, default 27: GPR index whose value 1 means pass (MODE 0).
REQ-006 Parameter CNT_W, default 32: cycle counter width.
REQ-007 Parameter TIMEOUT_CYCLES, default 1000000: watchdog limit in RUN cycles.
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 start  input  1  begins monitoring when sampled high in IDLE.
REQ-011 wen / waddr / wdata  input  1 / 5 / XLEN  snoop of the core's GPR write port.
REQ-012 halt  input  1  core halted (ebreak retired); used in MODE 1 only.
REQ-013 done / pass / fail / timeout  output  1 each  registered status flags.
REQ-014 fail_testnum  output  XLEN  test number latched at the terminal transition.
REQ-015 cycle_count  output  CNT_W  RUN cycles elapsed.

Function
REQ-016 FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are sticky until reset.
REQ-017 IDLE -> RUN on the edge where start=1; start is ignored in every other state.
REQ-018 Shadow copies of TESTNUM_REG, RESULT_REG and x10 update on wen=1 with a matching waddr, in every state except terminal; writes with waddr=0 are ignored.
REQ-019 MODE 0: in RUN, wen=1, waddr=END_REG, wdata=1 -> next state PASS if shadow RESULT_REG==1, else FAIL.
REQ-020 MODE 0: a write to END_REG with wdata!=1 does not end the test.
REQ-021 MODE 1: in RUN, halt=1 -> next state PASS if x10==0, else FAIL; a same-cycle write to x10 is forwarded into this decision.
REQ-022 Terminal transition takes effect 1 cycle after the triggering input; done=1 and exactly one of pass/fail/timeout=1 from that edge onward.
REQ-023 fail_testnum loads the shadow TESTNUM_REG value (same-cycle write forwarded) on the terminal transition and holds it.
REQ-024 cycle_count increments by 1 on every RUN cycle, saturates at all-ones, and freezes in terminal states.
REQ-025 Outputs are driven from registers only; there is no combinational input-to-output path.

Reset
REQ-026 rst=1 immediately forces state IDLE, all shadows 0, cycle_count 0, fail_testnum 0, and done/pass/fail/timeout 0, regardless of clk.
REQ-027 Reset asserted mid-RUN or in a terminal state discards all results; monitoring resumes only after a new start.

Configuration
REQ-028 Macro TEST_MONITOR_WDT_EN defined: when cycle_count == TIMEOUT_CYCLES-1 in RUN and no end condition is present, the next state is TIMEOUT.
REQ-029 When an end condition and the watchdog expiry occur in the same cycle, the end condition wins.
REQ-030 Macro TEST_MONITOR_WDT_EN undefined: no watchdog logic; TIMEOUT is unreachable; timeout is tied to 0.

Verification
REQ-031 MODE 0: start; write x3=5, x27=1, then x26=1 -> 1 cycle later done=1, pass=1, fail_testnum=5.
REQ-032 MODE 0: write x3=7, x27=0, x26=1 -> fail=1, fail_testnum=7; later writes do not change any output.
REQ-033 MODE 1: halt=1 in the same cycle as a write x10=0 -> pass=1 (forwarding); a repeat run with x10=3 -> fail=1.
REQ-034 WDT_EN defined, TIMEOUT_CYCLES=16, no end condition -> timeout=1 at cycle_count=15; end plus expiry in the same cycle -> pass/fail, not timeout.
REQ-035 rst pulsed mid-RUN between clock edges -> all outputs 0 immediately; writes to x26 before a new start have no effect.
REQ-036 CNT_W=4, WDT_EN undefined, 20 RUN cycles -> cycle_count saturates at 15; done stays 0.
